// File: rtl/topk_sort_sched_if.sv
// Bundle of the element stream, sorter and result-consumer signals of topk_sort_sched.
// The scheduler binds to the slave modport; the surrounding environment uses master.
interface topk_sort_sched_if #(
  parameter int DATAWIDTH  = 8,
  parameter int DATALENGTH = 16
);
  logic                                 in_vld_i;
  logic                                 in_rdy_o;
  logic [DATAWIDTH-1:0]                 in_data_i;
  logic                                 in_last_i;
  logic                                 srt_vld_o;
  logic [DATALENGTH-1:0][DATAWIDTH-1:0] srt_data_o;
  logic                                 srt_vld_i;
  logic [DATALENGTH-1:0][DATAWIDTH-1:0] srt_data_i;
  logic                                 out_vld_o;
  logic                                 out_rdy_i;
  logic [DATALENGTH-1:0][DATAWIDTH-1:0] out_data_o;
  logic [4:0]                           out_cnt_o;
  logic                                 out_last_o;
  logic                                 err_o;
  logic [31:0]                          perf_issue_o;
  logic [31:0]                          perf_stall_o;

  modport slave (
    input  in_vld_i, in_data_i, in_last_i, srt_vld_i, srt_data_i, out_rdy_i,
    output in_rdy_o, srt_vld_o, srt_data_o, out_vld_o, out_data_o, out_cnt_o,
           out_last_o, err_o, perf_issue_o, perf_stall_o
  );

  modport master (
    output in_vld_i, in_data_i, in_last_i, srt_vld_i, srt_data_i, out_rdy_i,
    input  in_rdy_o, srt_vld_o, srt_data_o, out_vld_o, out_data_o, out_cnt_o,
           out_last_o, err_o, perf_issue_o, perf_stall_o
  );
endinterface

// File: rtl/topk_sort_sched.sv
// Packs a scalar stream into padded 16-wide frames, issues them to a non-stallable
// sorter under credit control and buffers the sorted frames. Perf counters: TOPK_SCHED_PERF_EN.
module topk_sort_sched #(
  parameter int                   DATAWIDTH  = 8,
  parameter int                   DATALENGTH = 16,
  parameter int                   DEPTH      = 4,
  parameter int                   SORT_LAT   = 4,
  parameter logic [DATAWIDTH-1:0] PAD_VAL    = '0
) (
  input logic              clk_i,
  input logic              rst_i,
  topk_sort_sched_if.slave bus
);
  localparam int IW = $clog2(DATALENGTH);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = (SORT_LAT > 1) ? $clog2(SORT_LAT) : 1;

  localparam logic [1:0] ST_FLUSH = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;

  localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);
  localparam logic [PW:0]   FIFO_FULL  = (PW + 1)'(DEPTH);

  typedef logic [DATALENGTH-1:0][DATAWIDTH-1:0] frame_t;

  function automatic logic [CW-1:0] credit_return(input logic [CW-1:0] c);
    return (c == CREDIT_MAX) ? c : c + 1'b1;
  endfunction

  logic [1:0]    state;
  logic [FW-1:0] flush_cnt;
  logic [4:0]    cnt;
  logic [4:0]    frame_cnt;
  logic          frame_last;
  frame_t        frame_buf;
  frame_t        srt_frame;
  logic [CW-1:0] credit;

  logic accept, close, issue, ret;

  assign accept = (state == ST_FILL) && bus.in_vld_i;
  assign close  = accept && (bus.in_last_i || (cnt == 5'(DATALENGTH - 1)));
  assign issue  = (state == ST_ISSUE) && (credit != '0);
  assign ret    = bus.out_vld_o && bus.out_rdy_i;

  // Frame assembly: FLUSH waits out results still in the sorter after a reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_FLUSH;
      flush_cnt  <= '0;
      cnt        <= '0;
      frame_cnt  <= '0;
      frame_last <= 1'b0;
    end else begin
      case (state)
        ST_FLUSH: begin
          flush_cnt <= flush_cnt + 1'b1;
          if (flush_cnt == FW'(SORT_LAT - 1))
            state <= ST_FILL;
        end
        ST_FILL: begin
          if (accept) begin
            cnt <= cnt + 5'd1;
            if (close) begin
              frame_cnt  <= cnt + 5'd1;
              frame_last <= bus.in_last_i;
              state      <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            cnt   <= '0;
            state <= ST_FILL;
          end
        end
        default: state <= ST_FLUSH;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept)
      frame_buf[cnt[IW-1:0]] <= bus.in_data_i;
  end

  // Slots beyond the frame count may hold stale data from an earlier frame.
  always_comb begin
    srt_frame = '0;
    if (issue) begin
      for (int j = 0; j < DATALENGTH; j++)
        srt_frame[j] = (5'(j) < frame_cnt) ? frame_buf[j] : PAD_VAL;
    end
  end

  assign bus.srt_vld_o  = issue;
  assign bus.srt_data_o = srt_frame;
  assign bus.in_rdy_o   = (state == ST_FILL);

  always_ff @(posedge clk_i) begin
    if (rst_i)
      credit <= CREDIT_MAX;
    else if (issue && !ret)
      credit <= credit - 1'b1;
    else if (ret && !issue)
      credit <= credit_return(credit);
  end

  // Result FIFO (sorted frames) and side FIFO ({count, last}) pop together.
  frame_t        res_mem [DEPTH];
  logic [PW-1:0] res_rd, res_wr;
  logic [PW:0]   res_count;
  logic          res_push, res_drop, res_full, res_empty;
  logic          err;

  assign res_full  = (res_count == FIFO_FULL);
  assign res_empty = (res_count == '0);
  assign res_push  = bus.srt_vld_i && (state != ST_FLUSH) && (!res_full || ret);
  assign res_drop  = bus.srt_vld_i && (state != ST_FLUSH) && res_full && !ret;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_rd    <= '0;
      res_wr    <= '0;
      res_count <= '0;
      err       <= 1'b0;
    end else begin
      if (ret)
        res_rd <= res_rd + 1'b1;
      if (res_push)
        res_wr <= res_wr + 1'b1;
      if (res_push && !ret)
        res_count <= res_count + 1'b1;
      else if (ret && !res_push)
        res_count <= res_count - 1'b1;
      if (res_drop)
        err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (res_push)
      res_mem[res_wr] <= bus.srt_data_i;
  end

  logic [5:0]    side_mem [DEPTH];
  logic [5:0]    side_head;
  logic [PW-1:0] side_rd, side_wr;
  logic [PW:0]   side_count;
  logic          side_pop;

  assign side_pop  = ret && (side_count != '0);
  assign side_head = side_mem[side_rd];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      side_rd    <= '0;
      side_wr    <= '0;
      side_count <= '0;
    end else begin
      if (side_pop)
        side_rd <= side_rd + 1'b1;
      if (issue)
        side_wr <= side_wr + 1'b1;
      if (issue && !side_pop)
        side_count <= side_count + 1'b1;
      else if (side_pop && !issue)
        side_count <= side_count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (issue)
      side_mem[side_wr] <= {frame_cnt, frame_last};
  end

  assign bus.out_vld_o  = !res_empty;
  assign bus.out_data_o = res_empty ? '0 : res_mem[res_rd];
  assign bus.out_cnt_o  = (!res_empty && side_count != '0) ? side_head[5:1] : 5'd0;
  assign bus.out_last_o = (!res_empty && side_count != '0) ? side_head[0] : 1'b0;
  assign bus.err_o      = err;

`ifdef TOPK_SCHED_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_issue, perf_stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_issue <= '0;
      perf_stall <= '0;
    end else begin
      if (issue)
        perf_issue <= sat_inc32(perf_issue);
      if ((state == ST_ISSUE) && (credit == '0))
        perf_stall <= sat_inc32(perf_stall);
    end
  end

  assign bus.perf_issue_o = perf_issue;
  assign bus.perf_stall_o = perf_stall;
`else
  assign bus.perf_issue_o = 32'd0;
  assign bus.perf_stall_o = 32'd0;
`endif
endmodule

// File: tb/tb_topk_sort_sched.sv
// Directed bench for topk_sort_sched: a descending sorter model with fixed latency,
// a queue-based reference of frames/credits/results, and literal checks per scenario.
module tb_topk_sort_sched;
  localparam int DW = 8;
  localparam int DL = 16;
  localparam int DEPTH = 4;
  localparam int SORT_LAT = 4;
  localparam logic [DW-1:0] PAD_VAL = '0;

  typedef logic [DL-1:0][DW-1:0] frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  topk_sort_sched_if #(.DATAWIDTH(DW), .DATALENGTH(DL)) bus ();

  topk_sort_sched #(
    .DATAWIDTH(DW), .DATALENGTH(DL), .DEPTH(DEPTH), .SORT_LAT(SORT_LAT), .PAD_VAL(PAD_VAL)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int dut_issues = 0;
  int inj_left = 0;

  function automatic void chk(input string nm, input logic [DL*DW-1:0] act,
                              input logic [DL*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic frame_t sort_desc(input frame_t f);
    frame_t r;
    logic [DW-1:0] t;
    r = f;
    for (int i = 0; i < DL - 1; i++)
      for (int j = 0; j < DL - 1 - i; j++)
        if (r[j] < r[j+1]) begin
          t = r[j]; r[j] = r[j+1]; r[j+1] = t;
        end
    return r;
  endfunction

  // Sorter model: fixed latency, not affected by the scheduler reset.
  frame_t h_data [SORT_LAT];
  bit     h_vld  [SORT_LAT];
  initial begin
    for (int k = 0; k < SORT_LAT; k++) begin h_vld[k] = 0; h_data[k] = '0; end
    bus.srt_vld_i = 0;
    bus.srt_data_i = '0;
    forever begin
      @(posedge clk); #1;
      if (h_vld[SORT_LAT-1]) begin
        bus.srt_vld_i = 1;
        bus.srt_data_i = sort_desc(h_data[SORT_LAT-1]);
      end else if (inj_left > 0) begin
        bus.srt_vld_i = 1;
        for (int j = 0; j < DL; j++) bus.srt_data_i[j] = DW'(inj_left * 17 + j);
        inj_left--;
      end else begin
        bus.srt_vld_i = 0;
        bus.srt_data_i = '0;
      end
      for (int k = SORT_LAT - 1; k > 0; k--) begin
        h_vld[k] = h_vld[k-1];
        h_data[k] = h_data[k-1];
      end
      h_vld[0] = bus.srt_vld_o;
      h_data[0] = bus.srt_data_o;
    end
  end

  // Reference model state
  int         m_flush, m_out, m_idx;
  bit         m_pend, m_err;
  frame_t     m_fill;
  int         m_pi, m_ps;
  frame_t     expq[$];
  logic [5:0] expmeta[$];
  logic [5:0] sideq[$];
  frame_t     outq[$];
  bit         c_rdy, c_iss, c_ov, c_pop;
  logic [5:0] c_meta;

  always @(negedge clk) begin
    if (rst) begin
      m_flush = SORT_LAT; m_out = 0; m_idx = 0; m_pend = 0; m_err = 0;
      m_fill = {DL{PAD_VAL}}; m_pi = 0; m_ps = 0;
      expq.delete(); expmeta.delete(); sideq.delete(); outq.delete();
    end else begin
      c_rdy = (m_flush == 0) && !m_pend;
      c_iss = m_pend && (m_out < DEPTH);
      c_ov  = (outq.size() > 0);
      c_pop = c_ov && bus.out_rdy_i;
      chk("in_rdy", bus.in_rdy_o, c_rdy);
      chk("srt_vld", bus.srt_vld_o, c_iss);
      chk("out_vld", bus.out_vld_o, c_ov);
      chk("err", bus.err_o, m_err);
`ifdef TOPK_SCHED_PERF_EN
      chk("perf_issue", bus.perf_issue_o, m_pi);
      chk("perf_stall", bus.perf_stall_o, m_ps);
`else
      chk("perf_issue", bus.perf_issue_o, 0);
      chk("perf_stall", bus.perf_stall_o, 0);
`endif
      if (bus.srt_vld_o) dut_issues++;
      if (c_iss && expq.size() > 0) chk("srt_data", bus.srt_data_o, expq[0]);
      if (c_ov) begin
        chk("out_data", bus.out_data_o, outq[0]);
        if (sideq.size() > 0) begin
          c_meta = sideq[0];
          chk("out_cnt", bus.out_cnt_o, c_meta[5:1]);
          chk("out_last", bus.out_last_o, c_meta[0]);
        end
      end
      // state updates for the coming clock edge
      if (c_pop) begin
        void'(outq.pop_front());
        if (sideq.size() > 0) void'(sideq.pop_front());
      end
      if (c_iss) begin
        void'(expq.pop_front());
        sideq.push_back(expmeta.pop_front());
        m_pend = 0;
        m_pi++;
      end else if (m_pend) begin
        m_ps++;
      end
      if (c_iss && !c_pop) m_out++;
      else if (c_pop && !c_iss && m_out > 0) m_out--;
      if (bus.srt_vld_i && m_flush == 0) begin
        if (outq.size() < DEPTH) outq.push_back(bus.srt_data_i);
        else m_err = 1;
      end
      if (bus.in_vld_i && c_rdy) begin
        m_fill[m_idx] = bus.in_data_i;
        m_idx++;
        if (bus.in_last_i || m_idx == DL) begin
          expq.push_back(m_fill);
          expmeta.push_back({5'(m_idx), bus.in_last_i});
          m_pend = 1;
          m_idx = 0;
          m_fill = {DL{PAD_VAL}};
        end
      end
      if (m_flush > 0) m_flush--;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_elem(input logic [DW-1:0] d, input logic l);
    int n;
    bit ok;
    n = 0; ok = 0;
    bus.in_vld_i = 1; bus.in_data_i = d; bus.in_last_i = l;
    while (!ok && n < 400) begin
      @(negedge clk);
      ok = bus.in_rdy_o;
      n++;
    end
    @(posedge clk); #1;
    bus.in_vld_i = 0; bus.in_last_i = 0;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_rdy stayed 0, required 1 (t=%0t)", $time);
    end
  endtask

  task automatic send_full(input int base);
    for (int k = 0; k < DL; k++) send_elem(DW'(base + k), k == DL - 1);
  endtask

  task automatic wait_out_vld(input string nm);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_vld_o && n < 100);
    chk(nm, bus.out_vld_o, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_rdy_i = 1;
    while (n < 400 && (bus.out_vld_o || m_out != 0 || m_pend || expq.size() != 0)) begin
      @(negedge clk); n++;
    end
    chk("drain_done", (n < 400), 1);
    @(posedge clk); #1;
    bus.out_rdy_i = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    cycles(n);
    rst = 0;
  endtask

  int base_iss;

  initial begin
    bus.in_vld_i = 0; bus.in_data_i = '0; bus.in_last_i = 0; bus.out_rdy_i = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_rdy", bus.in_rdy_o, 0);
    chk("rst_srt_vld", bus.srt_vld_o, 0);
    chk("rst_srt_data", bus.srt_data_o, 0);
    chk("rst_out_vld", bus.out_vld_o, 0);
    chk("rst_out_data", bus.out_data_o, 0);
    chk("rst_out_cnt", bus.out_cnt_o, 0);
    chk("rst_out_last", bus.out_last_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_perf_issue", bus.perf_issue_o, 0);
    chk("rst_perf_stall", bus.perf_stall_o, 0);
    @(posedge clk); #1;
    rst = 0;

    // Full frame 1..16
    for (int k = 0; k < DL; k++) send_elem(DW'(k + 1), k == DL - 1);
    @(negedge clk);
    chk("t1_issue_strobe", bus.srt_vld_o, 1);
    chk("t1_srt_data", bus.srt_data_o, 128'h100f0e0d0c0b0a090807060504030201);
    @(posedge clk); #1;
    wait_out_vld("t1_out_vld");
    @(negedge clk);
    chk("t1_out_data", bus.out_data_o, 128'h0102030405060708090a0b0c0d0e0f10);
    chk("t1_out_cnt", bus.out_cnt_o, 16);
    chk("t1_out_last", bus.out_last_o, 1);
    @(posedge clk); #1;
    bus.out_rdy_i = 1;
    cycles(1);
    bus.out_rdy_i = 0;

    // Short frame {7,200,9}
    send_elem(8'd7, 0);
    send_elem(8'd200, 0);
    send_elem(8'd9, 1);
    @(negedge clk);
    chk("t2_srt_data", bus.srt_data_o, 128'h0000000000000000000000000009c807);
    @(posedge clk); #1;
    wait_out_vld("t2_out_vld");
    @(negedge clk);
    chk("t2_out_data", bus.out_data_o, 128'h000000000000000000000000000709c8);
    chk("t2_out_cnt", bus.out_cnt_o, 3);
    chk("t2_out_last", bus.out_last_o, 1);
    @(posedge clk); #1;
    drain();

    // Credit exhaustion
    base_iss = dut_issues;
    for (int f = 0; f < 5; f++) send_full(f * 16 + 3);
    cycles(30);
    @(negedge clk);
    chk("t3_issues_4", dut_issues - base_iss, 4);
    chk("t3_in_rdy_blocked", bus.in_rdy_o, 0);
    @(posedge clk); #1;
    bus.out_rdy_i = 1;
    cycles(1);
    bus.out_rdy_i = 0;
    cycles(10);
    @(negedge clk);
    chk("t3_issues_5", dut_issues - base_iss, 5);
    @(posedge clk); #1;
    bus.out_rdy_i = 1;
    send_full(100);
    drain();

    // Issue and return in the same cycle with one credit left
    for (int f = 0; f < 3; f++) send_elem(DW'(40 + f), 1);
    cycles(8);
    send_elem(8'd50, 1);
    bus.out_rdy_i = 1;
    @(negedge clk);
    chk("t4_issue", bus.srt_vld_o, 1);
    chk("t4_pop", bus.out_vld_o, 1);
    @(posedge clk); #1;
    bus.out_rdy_i = 0;
    send_elem(8'd51, 1);
    @(negedge clk);
    chk("t4_next_issue", bus.srt_vld_o, 1);
    @(posedge clk); #1;
    drain();

    // Reset two cycles after an issue; the returning frame is dropped silently
    send_elem(8'h55, 1);
    cycles(2);
    do_reset(1);
    cycles(15);
    @(negedge clk);
    chk("t5_out_vld", bus.out_vld_o, 0);
    chk("t5_err", bus.err_o, 0);
    @(posedge clk); #1;
    base_iss = dut_issues;
    for (int f = 0; f < DEPTH; f++) send_elem(DW'(60 + f), 1);
    cycles(10);
    @(negedge clk);
    chk("t5_credit_full", dut_issues - base_iss, DEPTH);
    @(posedge clk); #1;
    drain();

    // Forced overflow with unsolicited frames
    @(negedge clk);
    inj_left = DEPTH + 1;
    cycles(15);
    @(negedge clk);
    chk("t6_err_set", bus.err_o, 1);
    chk("t6_out_vld", bus.out_vld_o, 1);
    @(posedge clk); #1;
    bus.out_rdy_i = 1;
    cycles(10);
    bus.out_rdy_i = 0;
    @(negedge clk);
    chk("t6_err_sticky", bus.err_o, 1);
    chk("t6_empty", bus.out_vld_o, 0);
    @(posedge clk); #1;
    do_reset(2);
    cycles(2);
    @(negedge clk);
    chk("t6_err_cleared", bus.err_o, 0);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end
endmodule
